// File: rtl/game_state_controller.sv
// Round sequencer: title -> playing -> dying/game-over -> win, driving level
// reset, freeze, death blink and the elapsed-seconds timer.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   frame_clk           vsync-rate level; its rising edge is the frame tick
//   key_start           start key level; its rising edge is a start request
//   player1/2_dead      sticky death flags from the hazard blocks
//   player1/2_at_door   player overlaps its own exit door
//   game_state          0 title, 1 playing, 2 dying, 3 game over, 4 win
//   level_reset         one-cycle pulse into the hazard/player resets
//   freeze              high whenever not playing
//   dead_flash          renderer blink while dying
//   play_seconds        whole seconds elapsed in the current round
module game_state_controller #(
  parameter int DEATH_FRAMES   = 120,
  parameter int DOOR_FRAMES    = 30,
  parameter int FLASH_PERIOD   = 8,
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_MAX       = 999
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_start,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  output logic [2:0] game_state,
  output logic       level_reset,
  output logic       freeze,
  output logic       dead_flash,
  output logic [9:0] play_seconds
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam int OW = $clog2(DOOR_FRAMES + 1);
  localparam int FW = $clog2(FLASH_PERIOD + 1);
  localparam int SW = $clog2(FRAMES_PER_SEC + 1);

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_PLAYING   = 3'd1,
    S_DYING     = 3'd2,
    S_GAME_OVER = 3'd3,
    S_WIN       = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          frame_d, key_d;
  logic          lr, lr_nxt;
  logic          frz, frz_nxt;
  logic          flash, flash_nxt;
  logic [9:0]    secs, secs_nxt;
  logic [SW-1:0] sec_cnt, sec_cnt_nxt;
  logic [OW-1:0] door_cnt, door_cnt_nxt;
  logic [DW-1:0] death_cnt, death_cnt_nxt;
  logic [FW-1:0] flash_cnt, flash_cnt_nxt;

  logic tick;
  logic start;
  logic both_door;
  logic any_dead;

  assign tick      = frame_clk & ~frame_d;
  assign start     = key_start & ~key_d;
  assign both_door = player1_at_door & player2_at_door;
  assign any_dead  = player1_dead | player2_dead;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_TITLE;
      frame_d   <= 1'b1;
      key_d     <= 1'b1;
      lr        <= 1'b0;
      frz       <= 1'b1;
      flash     <= 1'b0;
      secs      <= '0;
      sec_cnt   <= '0;
      door_cnt  <= '0;
      death_cnt <= '0;
      flash_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_d   <= frame_clk;
      key_d     <= key_start;
      lr        <= lr_nxt;
      frz       <= frz_nxt;
      flash     <= flash_nxt;
      secs      <= secs_nxt;
      sec_cnt   <= sec_cnt_nxt;
      door_cnt  <= door_cnt_nxt;
      death_cnt <= death_cnt_nxt;
      flash_cnt <= flash_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lr_nxt        = 1'b0;
    flash_nxt     = flash;
    secs_nxt      = secs;
    sec_cnt_nxt   = sec_cnt;
    door_cnt_nxt  = door_cnt;
    death_cnt_nxt = death_cnt;
    flash_cnt_nxt = flash_cnt;

    unique case (state)
      S_TITLE, S_GAME_OVER: begin
        if (start) begin
          state_nxt    = S_PLAYING;
          lr_nxt       = 1'b1;
          secs_nxt     = '0;
          sec_cnt_nxt  = '0;
          door_cnt_nxt = '0;
        end
      end

      S_PLAYING: begin
        // Death flags are stale while our own level reset is in flight.
        if (!lr && any_dead) begin
          state_nxt     = S_DYING;
          death_cnt_nxt = DW'(DEATH_FRAMES);
          flash_cnt_nxt = '0;
          flash_nxt     = 1'b1;
        end else begin
          if (!both_door) begin
            door_cnt_nxt = '0;
          end else if (tick) begin
            door_cnt_nxt = door_cnt + OW'(1);
            if (door_cnt == OW'(DOOR_FRAMES - 1)) begin
              state_nxt = S_WIN;
            end
          end

          if (tick) begin
            if (sec_cnt == SW'(FRAMES_PER_SEC - 1)) begin
              sec_cnt_nxt = '0;
              if (secs != 10'(TIME_MAX)) begin
                secs_nxt = secs + 10'd1;
              end
            end else begin
              sec_cnt_nxt = sec_cnt + SW'(1);
            end
          end
        end
      end

      S_DYING: begin
        if (tick) begin
          if (death_cnt == DW'(1)) begin
            state_nxt = S_GAME_OVER;
            flash_nxt = 1'b0;
          end else begin
            death_cnt_nxt = death_cnt - DW'(1);
            if (flash_cnt == FW'(FLASH_PERIOD - 1)) begin
              flash_cnt_nxt = '0;
              flash_nxt     = ~flash;
            end else begin
              flash_cnt_nxt = flash_cnt + FW'(1);
            end
          end
        end
      end

      S_WIN: begin
        // No level reset: the final time stays on screen in TITLE.
        if (start) begin
          state_nxt = S_TITLE;
        end
      end

      default: begin
        state_nxt = S_TITLE;
      end
    endcase

    frz_nxt = (state_nxt != S_PLAYING);
  end

  assign game_state   = state;
  assign level_reset  = lr;
  assign freeze       = frz;
  assign dead_flash   = flash;
  assign play_seconds = secs;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller.
// TIME_MAX is lowered to keep the saturation run short.
module tb_game_state_controller;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       key_start;
  logic       player1_dead;
  logic       player2_dead;
  logic       player1_at_door;
  logic       player2_at_door;
  logic [2:0] game_state;
  logic       level_reset;
  logic       freeze;
  logic       dead_flash;
  logic [9:0] play_seconds;

  int checks = 0;
  int failures = 0;

  game_state_controller #(
    .DEATH_FRAMES(120),
    .DOOR_FRAMES(30),
    .FLASH_PERIOD(8),
    .FRAMES_PER_SEC(60),
    .TIME_MAX(12)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .key_start(key_start),
    .player1_dead(player1_dead),
    .player2_dead(player2_dead),
    .player1_at_door(player1_at_door),
    .player2_at_door(player2_at_door),
    .game_state(game_state),
    .level_reset(level_reset),
    .freeze(freeze),
    .dead_flash(dead_flash),
    .play_seconds(play_seconds)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
    end
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b1;
    key_start = 1'b1;
    player1_dead = 1'b0;
    player2_dead = 1'b0;
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    step();
    step();
    check("rst_state", game_state, 0);
    check("rst_lr", level_reset, 0);
    check("rst_freeze", freeze, 1);
    check("rst_flash", dead_flash, 0);
    check("rst_secs", play_seconds, 0);

    Reset = 1'b0;
    step();
    step();
    step();
    check("spur_state", game_state, 0);
    check("spur_lr", level_reset, 0);
    frame_clk = 1'b0;
    key_start = 1'b0;
    step();

    key_start = 1'b1;
    step();
    check("start_state", game_state, 1);
    check("start_lr", level_reset, 1);
    check("start_freeze", freeze, 0);
    check("start_secs", play_seconds, 0);
    key_start = 1'b0;
    step();
    check("start_lr_end", level_reset, 0);
    check("start_state2", game_state, 1);

    ticks(299);
    check("secs_299", play_seconds, 4);
    ticks(1);
    check("secs_300", play_seconds, 5);

    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    ticks(29);
    check("door_29", game_state, 1);
    player1_at_door = 1'b0;
    step();
    player1_at_door = 1'b1;
    ticks(29);
    check("door_rerun_29", game_state, 1);
    ticks(1);
    check("win_state", game_state, 4);
    check("win_freeze", freeze, 1);
    check("win_secs", play_seconds, 5);
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    ticks(60);
    check("win_secs_hold", play_seconds, 5);

    key_start = 1'b1;
    step();
    check("win_to_title", game_state, 0);
    check("win_to_title_lr", level_reset, 0);
    check("title_secs_keep", play_seconds, 5);
    step();
    check("held_no_retrig", game_state, 0);
    key_start = 1'b0;
    step();
    key_start = 1'b1;
    step();
    check("restart_state", game_state, 1);
    check("restart_lr", level_reset, 1);
    check("restart_secs", play_seconds, 0);
    key_start = 1'b0;
    step();

    player2_dead = 1'b1;
    step();
    check("die_state", game_state, 2);
    check("die_flash", dead_flash, 1);
    check("die_freeze", freeze, 1);
    ticks(7);
    check("flash_7", dead_flash, 1);
    ticks(1);
    check("flash_8", dead_flash, 0);
    ticks(8);
    check("flash_16", dead_flash, 1);
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step();
    check("die_ignore_start", game_state, 2);
    ticks(103);
    check("die_119_state", game_state, 2);
    check("die_119_flash", dead_flash, 1);
    ticks(1);
    check("gameover_state", game_state, 3);
    check("gameover_flash", dead_flash, 0);

    player2_dead = 1'b0;
    player1_dead = 1'b1;
    key_start = 1'b1;
    step();
    check("blank_state", game_state, 1);
    check("blank_lr", level_reset, 1);
    key_start = 1'b0;
    step();
    check("blank_masked", game_state, 1);
    check("blank_lr_end", level_reset, 0);
    player1_dead = 1'b0;
    step();
    check("blank_stay", game_state, 1);

    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    ticks(29);
    check("prio_pre", game_state, 1);
    player1_dead = 1'b1;
    frame_clk = 1'b1;
    step();
    check("prio_death", game_state, 2);
    frame_clk = 1'b0;
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    step();

    Reset = 1'b1;
    step();
    check("midrst_state", game_state, 0);
    check("midrst_lr", level_reset, 0);
    check("midrst_flash", dead_flash, 0);
    check("midrst_freeze", freeze, 1);
    Reset = 1'b0;
    player1_dead = 1'b0;
    step();

    key_start = 1'b1;
    step();
    check("sat_start", game_state, 1);
    key_start = 1'b0;
    step();
    ticks(720);
    check("sat_reach", play_seconds, 12);
    ticks(120);
    check("sat_hold", play_seconds, 12);
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    ticks(30);
    check("sat_win", game_state, 4);
    check("sat_win_secs", play_seconds, 12);
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    step();
    check("sat_title_secs", play_seconds, 12);
    key_start = 1'b1;
    step();
    check("sat_clear_secs", play_seconds, 0);
    check("sat_clear_lr", level_reset, 1);
    key_start = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
